esp_timeout_ctrl: RTL
=====================

// Module: esp_timeout_ctrl
// PURPOSE
//  Sequences the ms timer for one ESP8266 command/response transaction.
//  Pulses `send` to (re)transmit a command, then holds the external timer cleared or lets it
//  run, and watches its `cycles` count against a per-request timeout.
//  Retries with a fixed backoff, then reports done or fail to the Wi-Fi command FSM.
//  Sits between the Wi-Fi command FSM, the UART response parser and a timer instance.
// PARAMETERS
//  MAX_RETRY   3    retries after the first attempt (4 sends total).
//  RETRY_W     2    width of retry_cnt; must hold MAX_RETRY.
//  BACKOFF_MS  10   ms of timer count to wait between a timeout and the next send.
// PORTS
//  clk         in   1          system clock (50 MHz on the Nexys2).
//  rst         in   1          reset, asynchronous, active-high.
//  req         in   1          start a transaction; sampled only in IDLE.
//  timeout_ms  in   16         timeout per attempt, in timer cycles (ms); latched on req.
//  ack_rx      in   1          1-cycle pulse from the parser: a valid response was received.
//  cycles      in   16         ms count from the timer instance.
//  rst_timer   out  1          clear to the timer instance (timer clears synchronously).
//  send        out  1          1-cycle pulse: transmit the command now.
//  busy        out  1          high whenever state != IDLE.
//  done        out  1          1-cycle pulse: response received.
//  fail        out  1          1-cycle pulse: all attempts timed out.
//  retry_cnt   out  RETRY_W    retries used in the current or last transaction.
// BEHAVIOUR
//  All outputs are registered.
//  Reset (async) forces: state=IDLE, rst_timer=1, send=0, busy=0, done=0, fail=0,
//   retry_cnt=0, tmo_q=1.
//  States: IDLE, SEND, WAIT, BK_ARM, BACKOFF, DONE, FAIL.
//  IDLE:    rst_timer=1.
//           On req: tmo_q <= (timeout_ms==0) ? 1 : timeout_ms; retry_cnt <= 0; -> SEND.
//  SEND:    exactly 1 cycle; send=1, rst_timer=1; -> WAIT.
//  WAIT:    rst_timer=0.
//           ack_rx -> DONE.
//           else if cycles >= tmo_q:
//             retry_cnt == MAX_RETRY -> FAIL;
//             else retry_cnt++ -> BK_ARM.
//  BK_ARM:  1 cycle; rst_timer=1; -> BACKOFF.
//  BACKOFF: rst_timer=0.
//           ack_rx (late response) -> DONE.
//           else if cycles >= BACKOFF_MS -> SEND.
//  DONE:    1 cycle; done=1; -> IDLE.
//  FAIL:    1 cycle; fail=1; -> IDLE.
//  Priority: ack_rx beats a simultaneous timeout in WAIT and BACKOFF.
//  req while busy is ignored and is not queued. ack_rx in IDLE, SEND or BK_ARM is ignored.
//  retry_cnt holds its value after DONE/FAIL until the next accepted req.
//  Latency:
//   - req to send pulse: 1 cycle.
//   - ack_rx to done pulse: 1 cycle.
//   - cycles reaching tmo_q on the last attempt to fail pulse: 1 cycle.
//  Comparisons are unsigned and 16 bit. The timer wraps 65535 -> 0, which is unreachable
//   because tmo_q <= 65535 ends WAIT first.
//  rst asserted mid-transaction: immediate return to reset values; no done/fail is issued.
// STRUCTURE
//  Shared package/header: state encodings (3-bit localparams) and the ESP8266 timing
//   constants (BACKOFF_MS and the default timeout values for AT commands).
//  No sub-module. The timer is instantiated beside this block at the Wi-Fi top level.
//  One FSM plus the tmo_q and retry_cnt registers.
// TESTING  (timer instance with PERIOD=4 so that 1 ms = 4 clk)
//  1. req, timeout_ms=5, ack_rx at cycles=3
//     -> one send pulse, done 1 cycle after ack, retry_cnt=0, busy low after done.
//  2. req, timeout_ms=5, no ack
//     -> 4 send pulses, each separated by a timeout plus a 10 ms backoff;
//        fail 1 cycle after cycles=5 on the 4th attempt; retry_cnt=3; done never high.
//  3. ack_rx in the same cycle that cycles reaches tmo_q -> done=1, fail=0, no further send.
//  4. timeout_ms=0 -> treated as 1: timeout taken at cycles=1.
//     Then ack_rx during BACKOFF -> done, no further send.
//  5. Second req while busy -> ignored; timeout_ms stays at the first value; one send only.
//  6. rst pulsed mid-WAIT
//     -> outputs at reset values in the same cycle, rst_timer=1, no done/fail;
//        a new req afterwards behaves as in test 1.

Source files
------------

// File: rtl/esp_timeout_ctrl_pkg.sv
// Shared encodings and ESP8266 timing constants for the command timeout sequencer.
package esp_timeout_ctrl_pkg;

  localparam int unsigned MAX_RETRY_DEF  = 3;
  localparam int unsigned RETRY_W_DEF    = 2;
  localparam int unsigned BACKOFF_MS_DEF = 10;
  localparam int unsigned TMO_W          = 16;

  // Default per-command response timeouts in ms.
  localparam int unsigned TMO_AT_MS       = 1000;
  localparam int unsigned TMO_CWJAP_MS    = 20000;
  localparam int unsigned TMO_CIPSTART_MS = 10000;
  localparam int unsigned TMO_CIPSEND_MS  = 5000;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SEND    = 3'd1;
  localparam logic [2:0] ST_WAIT    = 3'd2;
  localparam logic [2:0] ST_BK_ARM  = 3'd3;
  localparam logic [2:0] ST_BACKOFF = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;
  localparam logic [2:0] ST_FAIL    = 3'd6;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    SEND    = ST_SEND,
    WAIT    = ST_WAIT,
    BK_ARM  = ST_BK_ARM,
    BACKOFF = ST_BACKOFF,
    DONE    = ST_DONE,
    FAIL    = ST_FAIL
  } state_e;

endpackage

// File: rtl/esp_timeout_ctrl.sv
// Sequences send / timeout / retry-with-backoff for one ESP8266 command transaction,
// driving the clear of an external ms timer and watching its count.
module esp_timeout_ctrl
  import esp_timeout_ctrl_pkg::*;
#(
  parameter int unsigned MAX_RETRY  = MAX_RETRY_DEF,
  parameter int unsigned RETRY_W    = RETRY_W_DEF,
  parameter int unsigned BACKOFF_MS = BACKOFF_MS_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req,
  input  logic [TMO_W-1:0]   timeout_ms,
  input  logic               ack_rx,
  input  logic [TMO_W-1:0]   cycles,
  output logic               rst_timer,
  output logic               send,
  output logic               busy,
  output logic               done,
  output logic               fail,
  output logic [RETRY_W-1:0] retry_cnt
);

  state_e             state_q, state_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [RETRY_W-1:0] retry_cnt_q, retry_cnt_d;
  logic               rst_timer_q, rst_timer_d;
  logic               send_q, send_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               fail_q, fail_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      tmo_q       <= TMO_W'(1);
      retry_cnt_q <= '0;
      rst_timer_q <= 1'b1;
      send_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      retry_cnt_q <= retry_cnt_d;
      rst_timer_q <= rst_timer_d;
      send_q      <= send_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
    end
  end

  // Next state; ack_rx takes priority over a simultaneous timeout.
  always_comb begin
    state_d     = state_q;
    tmo_d       = tmo_q;
    retry_cnt_d = retry_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          tmo_d       = (timeout_ms == TMO_W'(0)) ? TMO_W'(1) : timeout_ms;
          retry_cnt_d = '0;
          state_d     = SEND;
        end
      end
      SEND:   state_d = WAIT;
      WAIT: begin
        if (ack_rx) begin
          state_d = DONE;
        end else if (cycles >= tmo_q) begin
          if (retry_cnt_q == RETRY_W'(MAX_RETRY)) begin
            state_d = FAIL;
          end else begin
            retry_cnt_d = retry_cnt_q + RETRY_W'(1);
            state_d     = BK_ARM;
          end
        end
      end
      BK_ARM: state_d = BACKOFF;
      BACKOFF: begin
        if (ack_rx) begin
          state_d = DONE;
        end else if (cycles >= TMO_W'(BACKOFF_MS)) begin
          state_d = SEND;
        end
      end
      DONE:    state_d = IDLE;
      FAIL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    rst_timer_d = 1'b0;
    send_d      = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    fail_d      = 1'b0;
    rst_timer_d = (state_d == IDLE) || (state_d == SEND) || (state_d == BK_ARM);
    send_d      = (state_d == SEND);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
    fail_d      = (state_d == FAIL);
  end

  assign rst_timer = rst_timer_q;
  assign send      = send_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign fail      = fail_q;
  assign retry_cnt = retry_cnt_q;

endmodule
